// File: rtl/unswap_pkg.sv
// Shared constants, pair type and pointer sizing for the unswap receive path.
package unswap_pkg;

  localparam int UNSWAP_WIDTH = 8;
  localparam int UNSWAP_DEPTH = 4;
  localparam int UNSWAP_CNT_W = 8;

  typedef struct packed {
    logic [UNSWAP_WIDTH-1:0] c;
    logic [UNSWAP_WIDTH-1:0] d;
  } pair_t;

  // Address bits plus one wrap bit, so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/unswap_rx_pair_fifo.sv
// First-word fall-through FIFO of restored pairs; DEPTH must be a power of two >= 2.
module pair_fifo
  import unswap_pkg::*;
#(
  parameter int DW    = 2 * UNSWAP_WIDTH,
  parameter int DEPTH = UNSWAP_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone decide
  // which entries are valid, and an unreset array maps onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/unswap_rx.sv
// Restores swapped pairs (c_out = sw_d, d_out = sw_c) through a small FIFO.
// Define UNSWAP_STICKY_OVF_EN to make ovf hold after the first drop until rst.
module unswap_rx
  import unswap_pkg::*;
#(
  parameter int WIDTH = UNSWAP_WIDTH,
  parameter int DEPTH = UNSWAP_DEPTH,
  parameter int CNT_W = UNSWAP_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sw_c,
  input  logic [WIDTH-1:0] sw_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] d_out,
  output logic [CNT_W-1:0] pair_cnt,
  output logic             ovf
);

  typedef struct packed {
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
  } rx_pair_t;

  rx_pair_t wr_pair;
  rx_pair_t rd_pair;
  logic     full;
  logic     empty;
  logic     push;
  logic     pop;
  logic     drop;

  assign wr_pair = '{c: sw_d, d: sw_c};

  // Handshakes depend only on registered pointers, never on in_valid/out_ready.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign drop      = in_valid && !in_ready;

  pair_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_pair),
    .rdata (rd_pair),
    .full  (full),
    .empty (empty)
  );

  assign c_out = rd_pair.c;
  assign d_out = rd_pair.d;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (pop) pair_cnt <= pair_cnt + 1'b1;
`ifdef UNSWAP_STICKY_OVF_EN
      ovf <= ovf || drop;
`else
      ovf <= drop;
`endif
    end
  end

endmodule

// File: tb/tb_unswap_rx.sv
// Scoreboard bench for unswap_rx: stimulus queues expected pairs, monitor pops and compares.
module tb_unswap_rx;
  import unswap_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] sw_c;
  logic [7:0] sw_d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] c_out;
  logic [7:0] d_out;
  logic [7:0] pair_cnt;
  logic       ovf;

  int    checks = 0;
  int    errors = 0;
  pair_t sb_q[$];

  unswap_rx dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sw_c      (sw_c),
    .sw_d      (sw_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out),
    .d_out     (d_out),
    .pair_cnt  (pair_cnt),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one pair; the restored order is what the scoreboard expects back.
  task automatic drive(input logic [7:0] c, input logic [7:0] d, input bit expect_out);
    in_valid = 1'b1;
    sw_c     = c;
    sw_d     = d;
    if (expect_out) sb_q.push_back('{c: d, d: c});
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        pair_t exp;
        exp = sb_q.pop_front();
        check("c_out", {24'd0, c_out}, {24'd0, exp.c});
        check("d_out", {24'd0, d_out}, {24'd0, exp.d});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sw_c = '0; sw_d = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pair_cnt",  {24'd0, pair_cnt},  32'd0);
    check("rst_ovf",       {31'd0, ovf},       32'd0);

    // 1: single pair, one-cycle latency
    out_ready = 1'b1;
    drive(8'h02, 8'h01, 1'b1);
    tick();
    in_valid = 1'b0;
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    tick();
    check("t1_pair_cnt",  {24'd0, pair_cnt},  32'd1);
    check("t1_out_valid_after", {31'd0, out_valid}, 32'd0);

    // 2: fill to full with downstream stalled
    out_ready = 1'b0;
    drive(8'h08, 8'h05, 1'b1); tick();
    drive(8'h00, 8'hFF, 1'b1); tick();
    drive(8'h0A, 8'h0B, 1'b1); tick();
    drive(8'h0C, 8'h0D, 1'b1); tick();
    check("t2_full_in_ready", {31'd0, in_ready}, 32'd0);

    // 3: push into full FIFO while popping -> dropped, no push-through
    drive(8'h11, 8'h22, 1'b0);
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t3_ovf",       {31'd0, ovf},       32'd1);
    check("t3_in_ready",  {31'd0, in_ready},  32'd1);
    check("t3_out_valid", {31'd0, out_valid}, 32'd1);
    tick();
`ifdef UNSWAP_STICKY_OVF_EN
    check("t3_ovf_hold", {31'd0, ovf}, 32'd1);
`else
    check("t3_ovf_pulse", {31'd0, ovf}, 32'd0);
`endif
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("t3_drained",  {31'd0, out_valid}, 32'd0);
    check("t3_pair_cnt", {24'd0, pair_cnt},  32'd5);
    check("t3_sb_empty", sb_q.size(),        32'd0);

    // 4: streaming 300 pairs from a fresh reset
    rst = 1'b1; in_valid = 1'b0; tick(); rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      check("t4_no_stall", {31'd0, in_ready}, 32'd1);
      drive(8'(i), 8'(i + 1), 1'b1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("t4_pair_cnt",  {24'd0, pair_cnt},  32'd44);
    check("t4_out_valid", {31'd0, out_valid}, 32'd0);
    check("t4_sb_empty",  sb_q.size(),        32'd0);

    // 5: reset discards stored pairs
    out_ready = 1'b0;
    drive(8'hA1, 8'hA2, 1'b0); tick();
    drive(8'hB1, 8'hB2, 1'b0); tick();
    in_valid = 1'b0;
    check("t5_stored", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_in_ready",  {31'd0, in_ready},  32'd1);
    check("t5_pair_cnt",  {24'd0, pair_cnt},  32'd0);
    check("t5_ovf",       {31'd0, ovf},       32'd0);
    out_ready = 1'b1;
    drive(8'h33, 8'h44, 1'b1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("t5_out_valid_end", {31'd0, out_valid}, 32'd0);
    check("t5_pair_cnt_end",  {24'd0, pair_cnt},  32'd1);
    check("t5_sb_empty",      sb_q.size(),        32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unswap_rx.md
Name: unswap_rx

Overview:
Receive-side counterpart to the registered byte-pair swapper. Accepts swapped pairs (sw_c, sw_d) over a valid/ready handshake and restores their original order (c_out = sw_d, d_out = sw_c). Buffers pairs in a small FIFO and presents them downstream with a valid/ready handshake. Counts delivered pairs and flags dropped input attempts.

Parameters:
WIDTH, 8, bit width of each element of the pair
DEPTH, 4, FIFO entries; power of two, minimum 2
CNT_W, 8, width of delivered-pair counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream presents a swapped pair
in_ready  output  1  FIFO can accept a pair (not full)
sw_c  input  WIDTH  swapped element (originally d)
sw_d  input  WIDTH  swapped element (originally c)
out_valid  output  1  restored pair available (not empty)
out_ready  input  1  downstream accepts the pair
c_out  output  WIDTH  restored c (= sw_d of head entry)
d_out  output  WIDTH  restored d (= sw_c of head entry)
pair_cnt  output  CNT_W  pairs delivered since reset
ovf  output  1  drop indicator (see below)

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: in_ready=1, out_valid=0, pair_cnt=0, ovf=0, read/write pointers=0, occupancy=0. c_out/d_out are don't-care while out_valid=0.
- Reset asserted mid-operation discards all stored pairs. out_valid=0 and in_ready=1 from the cycle after the reset edge.
- Storage: register array of DEPTH entries, each {restored c, restored d}. Pointers are log2(DEPTH)+1 bits with a wrap bit; full = addresses equal and wrap bits differ; empty = pointers equal.
- Push = in_valid && in_ready. At the edge, writes {sw_d, sw_c} to wr_ptr and increments wr_ptr.
- Pop = out_valid && out_ready. At the edge, increments rd_ptr.
- in_ready = !full; out_valid = !empty. Both are combinational from registered pointers, with no combinational path from in_valid or out_ready.
- First-word fall-through: c_out/d_out come from the head entry. A pair pushed at edge N is visible with out_valid=1 in cycle N+1, giving 1-cycle latency.
- Empty: no bypass; a push into an empty FIFO becomes visible the next cycle.
- Full: in_ready=0 even if a pop occurs in the same cycle; no push-through when full.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged, both pointers advance.
- Pointer wrap-around after DEPTH operations is seamless; ordering is strictly FIFO.
- pair_cnt increments by 1 on each pop and wraps 2^CNT_W-1 -> 0.
- Drop: in_valid && !in_ready is a drop; the pair is not stored.
- ovf, default: registered one-cycle pulse in the cycle after each drop.

Optional Feature:
- Macro UNSWAP_STICKY_OVF_EN.
- Defined: ovf is sticky; set in the cycle after the first drop and held until rst.
- Not defined: ovf is the one-cycle pulse described above.
- Port list is identical in both builds.

Decomposition:
- Shared package unswap_pkg:
  - default WIDTH/DEPTH/CNT_W constants
  - pair typedef (struct of c and d, WIDTH each)
  - pointer-width function (clog2(DEPTH)+1)
- One natural sub-module: pair_fifo (storage, pointers, full/empty).
- unswap_rx keeps the swap mapping, pair_cnt and ovf logic.

Test Plan:
1. Reset then push sw_c=8'h02, sw_d=8'h01, out_ready=1 -> next cycle out_valid=1, c_out=8'h01, d_out=8'h02; after the pop pair_cnt=1, out_valid=0.
2. out_ready=0; push (8'h08,8'h05), (8'h00,8'hFF), (8'h0A,8'h0B), (8'h0C,8'h0D) -> in_ready=0 after the 4th; then drain -> c_out sequence 05,FF,0B,0D in order.
3. FIFO full, in_valid=1 with pair (8'h11,8'h22) and pop in the same cycle -> pair not stored; ovf=1 for one cycle (default) or stays 1 (UNSWAP_STICKY_OVF_EN); occupancy=3.
4. Continuous push and pop every cycle for 300 pairs with incrementing data -> every output matches the swapped input in order, no stalls, pair_cnt=300 mod 256=44.
5. Two pairs stored, assert rst for one cycle -> out_valid=0, in_ready=1, pair_cnt=0, ovf=0 next cycle; the following push delivers only the new pair.
